// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-locked write-port arbiter in front of synch_fifo
// Optional FIFO_ARB_ROOM_CHECK_EN: grant only when the FIFO has room for a maximum-length packet.
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FIFO_PTR    = 4,
  parameter int FIFO_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                          i_fifo_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  input  logic [FIFO_PTR:0]             i_fifo_room_avail,
  output logic                          o_fifo_wren,
  output logic [FIFO_WIDTH-1:0]         o_fifo_wrdata,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_busy,
  output logic                          o_pkt_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_LEN);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_pkt_err;
  logic [ID_W-1:0]   w_winner;
  logic              w_any;
  logic              w_start;
  logic              w_g_valid;
  logic              w_g_last;
  logic              w_xfer;
  logic              w_done;
  logic              w_overlong;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_any = |i_req_valid;

`ifdef FIFO_ARB_ROOM_CHECK_EN
  localparam logic [FIFO_PTR:0] ROOM_NEED = (FIFO_PTR + 1)'(MAX_PKT_LEN);
  assign w_start = w_any & (i_fifo_room_avail >= ROOM_NEED);
`else
  logic w_unused_room;
  assign w_unused_room = ^i_fifo_room_avail;
  assign w_start       = w_any;
`endif

  // Descending scan so the requester closest after last_grant is assigned last and wins.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    v_idx    = '0;
    w_winner = r_last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (i_req_valid[v_idx]) w_winner = v_idx;
    end
  end

  assign w_g_valid  = i_req_valid[r_grant_id];
  assign w_g_last   = i_req_last[r_grant_id];
  assign w_xfer     = (r_state == S_LOCK) & w_g_valid & ~i_fifo_full;
  assign w_cnt_inc  = r_beat_cnt + 1'b1;
  assign w_overlong = w_xfer & ~w_g_last & (w_cnt_inc == MAX_CNT);
  assign w_done     = w_xfer & (w_g_last | w_overlong);

  always_ff @(posedge i_fifo_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_LOCK;
      S_LOCK:  if (w_done)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready   = '0;
    o_fifo_wren   = 1'b0;
    o_fifo_wrdata = '0;
    if (r_state == S_LOCK) begin
      o_req_ready[r_grant_id] = ~i_fifo_full;
      o_fifo_wren             = w_g_valid & ~i_fifo_full;
      o_fifo_wrdata           = i_req_data[int'(r_grant_id)*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge i_fifo_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_pkt_err    <= 1'b0;
    end else begin
      r_pkt_err <= w_overlong;
      if ((r_state == S_IDLE) && w_start) begin
        r_grant_id <= w_winner;
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= w_cnt_inc;
      end
      if (w_done) r_last_grant <= r_grant_id;
    end
  end

  assign o_grant_id = r_grant_id;
  assign o_busy     = (r_state == S_LOCK);
  assign o_pkt_err  = r_pkt_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a behavioural FIFO occupancy model
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic [4:0]   room;
  logic         wren;
  logic [31:0]  wrdata;
  logic [1:0]   gid;
  logic         busy;
  logic         pkt_err;

  int           fifo_cnt;
  int           n_tests;
  int           n_fail;
  int           wr_count;
  int           sb_rd;
  int           rd_ptr [4];
  logic [32:0]  pq [4][$];
  logic [33:0]  sb [$];

  assign fifo_full = (fifo_cnt == 16);
  assign room      = 5'(16 - fifo_cnt);

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_PTR(4), .FIFO_WIDTH(32), .MAX_PKT_LEN(8)) dut (
    .i_fifo_clk        (clk),
    .i_rst             (rst),
    .i_req_valid       (req_valid),
    .i_req_last        (req_last),
    .i_req_data        (req_data),
    .o_req_ready       (req_ready),
    .i_fifo_full       (fifo_full),
    .i_fifo_room_avail (room),
    .o_fifo_wren       (wren),
    .o_fifo_wrdata     (wrdata),
    .o_grant_id        (gid),
    .o_busy            (busy),
    .o_pkt_err         (pkt_err)
  );

  function automatic logic [31:0] mkd(input int r, input int n);
    return 32'hD000_0000 | 32'(r << 8) | 32'(n);
  endfunction

  task automatic load(input int r, input int n, input bit last);
    pq[r].push_back({last, mkd(r, n)});
  endtask

  task automatic expect_wr(input int r, input int n);
    sb.push_back({2'(r), mkd(r, n)});
  endtask

  // Sample at the negedge, advance one clock, retire the sampled write and move producers and FIFO model.
  task automatic step(input bit rd);
    logic        s_wren;
    logic [31:0] s_data;
    logic [1:0]  s_gid;
    logic [3:0]  s_xfer;
    logic [33:0] exp_v;
    logic [32:0] head;
    int          rdv;
    s_wren = wren;
    s_data = wrdata;
    s_gid  = gid;
    s_xfer = req_valid & req_ready;
    if (s_wren) begin
      n_tests++;
      if (fifo_full) begin
        n_fail++;
        $display("FAIL write_while_full: wren=%0b with full=1, required wren=0", s_wren);
      end
    end
    @(posedge clk);
    #1;
    if (s_wren) begin
      n_tests++;
      if (sb_rd >= sb.size()) begin
        n_fail++;
        $display("FAIL unexpected_write: got id=%0d data=%h, required no write", s_gid, s_data);
      end else begin
        exp_v = sb[sb_rd];
        sb_rd++;
        if ({s_gid, s_data} !== exp_v) begin
          n_fail++;
          $display("FAIL sb_write: got id=%0d data=%h, required id=%0d data=%h",
                   s_gid, s_data, exp_v[33:32], exp_v[31:0]);
        end
      end
      wr_count++;
    end
    rdv      = (rd && fifo_cnt > 0) ? 1 : 0;
    fifo_cnt = fifo_cnt + (s_wren ? 1 : 0) - rdv;
    for (int i = 0; i < 4; i++) begin
      if (s_xfer[i]) rd_ptr[i]++;
      if (rd_ptr[i] < pq[i].size()) begin
        head               = pq[i][rd_ptr[i]];
        req_valid[i]       = 1'b1;
        req_last[i]        = head[32];
        req_data[i*32 +: 32] = head[31:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*32 +: 32] = 32'h0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    fifo_cnt = 0;
    step(1'b0);
    step(1'b0);
    rst      = 1'b0;
    wr_count = 0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({gid, busy, pkt_err, req_ready, wren, wrdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gid=%0d busy=%0b err=%0b rdy=%b wren=%0b data=%h, required all 0",
               gid, busy, pkt_err, req_ready, wren, wrdata);
    end
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    n_tests++;
    if ({busy, gid, wren} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%0b gid=%0d wren=%0b, required 0/0/0", busy, gid, wren);
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      load(0, n, n == 2);
      expect_wr(0, n);
    end
    step(1'b0);
    n_tests++;
    if (busy !== 1'b0 || wren !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_arb_cycle: got busy=%0b wren=%0b, required 0/0", busy, wren);
    end
    step(1'b0);
    n_tests++;
    if (busy !== 1'b1 || gid !== 2'd0 || wren !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_grant: got busy=%0b gid=%0d wren=%0b, required 1/0/1", busy, gid, wren);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      n_tests++;
      if (wren !== 1'b1) begin
        n_fail++;
        $display("FAIL t1_consecutive: beat %0d got wren=%0b, required 1", k + 2, wren);
      end
    end
    step(1'b0);
    n_tests++;
    if (busy !== 1'b0 || wren !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_release: got busy=%0b wren=%0b, required 0/0", busy, wren);
    end
    n_tests++;
    if (sb_rd != sb.size()) begin
      n_fail++;
      $display("FAIL t1_drain: got %0d writes retired, required %0d", sb_rd, sb.size());
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) begin
        load(r, p, 1'b1);
        expect_wr(r, p);
      end
    for (int k = 0; k < 100 && sb_rd < sb.size(); k++) step(1'b0);
    n_tests++;
    if (sb_rd != sb.size()) begin
      n_fail++;
      $display("FAIL t2_drain: got %0d writes retired, required %0d", sb_rd, sb.size());
    end
    step(1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_idle: got busy=%0b, required 0", busy);
    end
  endtask

`ifndef FIFO_ARB_ROOM_CHECK_EN
  task automatic test_full_stall();
    apply_reset();
    fifo_cnt = 14;
    for (int n = 0; n < 4; n++) begin
      load(1, n, n == 3);
      expect_wr(1, n);
    end
    for (int k = 0; k < 20 && !fifo_full; k++) step(1'b0);
    n_tests++;
    if (fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_fill_timeout: got full=%0b, required 1", fifo_full);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (wren !== 1'b0 || req_ready[1] !== 1'b0 || busy !== 1'b1 || gid !== 2'd1) begin
        n_fail++;
        $display("FAIL t3_stall: got wren=%0b rdy1=%0b busy=%0b gid=%0d, required 0/0/1/1",
                 wren, req_ready[1], busy, gid);
      end
      if (k < 2) step(1'b0);
    end
    step(1'b1);
    n_tests++;
    if (wren !== 1'b1 || req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_resume: got wren=%0b rdy1=%0b, required 1/1", wren, req_ready[1]);
    end
    for (int k = 0; k < 100 && sb_rd < sb.size(); k++) step(1'b1);
    step(1'b1);
    n_tests++;
    if (sb_rd != sb.size() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_drain: got %0d retired busy=%0b, required %0d retired busy=0", sb_rd, busy, sb.size());
    end
  endtask
`endif

  task automatic test_overlong();
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      load(2, n, n == 9);
      expect_wr(2, n);
    end
    for (int k = 0; k < 40 && wr_count < 7; k++) step(1'b0);
    n_tests++;
    if (pkt_err !== 1'b0 || busy !== 1'b1 || wr_count != 7) begin
      n_fail++;
      $display("FAIL t4_before: got err=%0b busy=%0b writes=%0d, required 0/1/7", pkt_err, busy, wr_count);
    end
    step(1'b0);
    n_tests++;
    if (pkt_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_pkt_err: got err=%0b busy=%0b, required 1/0", pkt_err, busy);
    end
    step(1'b0);
    n_tests++;
    if (pkt_err !== 1'b0 || busy !== 1'b1 || gid !== 2'd2) begin
      n_fail++;
      $display("FAIL t4_regrant: got err=%0b busy=%0b gid=%0d, required 0/1/2", pkt_err, busy, gid);
    end
    for (int k = 0; k < 100 && sb_rd < sb.size(); k++) step(1'b0);
    step(1'b0);
    n_tests++;
    if (sb_rd != sb.size() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_drain: got %0d retired busy=%0b, required %0d retired busy=0", sb_rd, busy, sb.size());
    end
  endtask

  task automatic test_reset_in_lock();
    apply_reset();
    for (int n = 0; n < 4; n++) load(1, n, n == 3);
    expect_wr(1, 0);
    expect_wr(1, 1);
    for (int k = 0; k < 4; k++) step(1'b0);
    n_tests++;
    if (busy !== 1'b1 || gid !== 2'd1 || wr_count != 2) begin
      n_fail++;
      $display("FAIL t5_mid_packet: got busy=%0b gid=%0d writes=%0d, required 1/1/2", busy, gid, wr_count);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({gid, busy, pkt_err, req_ready, wren, wrdata} !== 40'h0) begin
      n_fail++;
      $display("FAIL t5_reset_outputs: got gid=%0d busy=%0b err=%0b rdy=%b wren=%0b data=%h, required all 0",
               gid, busy, pkt_err, req_ready, wren, wrdata);
    end
    load(0, 0, 1'b1);
    step(1'b0);
    rst = 1'b0;
    expect_wr(0, 0);
    expect_wr(1, 2);
    expect_wr(1, 3);
    step(1'b0);
    n_tests++;
    if (busy !== 1'b1 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL t5_first_grant: got busy=%0b gid=%0d, required 1/0", busy, gid);
    end
    for (int k = 0; k < 100 && sb_rd < sb.size(); k++) step(1'b0);
    n_tests++;
    if (sb_rd != sb.size()) begin
      n_fail++;
      $display("FAIL t5_drain: got %0d writes retired, required %0d", sb_rd, sb.size());
    end
  endtask

`ifdef FIFO_ARB_ROOM_CHECK_EN
  task automatic test_room_check();
    apply_reset();
    fifo_cnt = 11;
    for (int n = 0; n < 4; n++) begin
      load(3, n, n == 3);
      expect_wr(3, n);
    end
    for (int k = 0; k < 6; k++) begin
      step(k >= 3);
      n_tests++;
      if (busy !== 1'b0 || wren !== 1'b0) begin
        n_fail++;
        $display("FAIL t6_no_grant: cycle %0d room=%0d got busy=%0b wren=%0b, required 0/0", k, room, busy, wren);
      end
    end
    step(1'b0);
    n_tests++;
    if (busy !== 1'b1 || gid !== 2'd3) begin
      n_fail++;
      $display("FAIL t6_grant: got busy=%0b gid=%0d, required 1/3", busy, gid);
    end
    for (int k = 0; k < 100 && sb_rd < sb.size(); k++) step(1'b0);
    step(1'b0);
    n_tests++;
    if (sb_rd != sb.size() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_drain: got %0d retired busy=%0b, required %0d retired busy=0", sb_rd, busy, sb.size());
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_cnt  = 0;
    n_tests   = 0;
    n_fail    = 0;
    wr_count  = 0;
    sb_rd     = 0;
    for (int i = 0; i < 4; i++) rd_ptr[i] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
`ifndef FIFO_ARB_ROOM_CHECK_EN
    test_full_stall();
`endif
    test_overlong();
    test_reset_in_lock();
`ifdef FIFO_ARB_ROOM_CHECK_EN
    test_room_check();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
